// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, pointer auto-increment and open-drain SDA.
// Optional glitch filter on SCL/SDA enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regfile #(
  parameter logic [6:0] DEVICE_ADDR    = 7'h50,
  parameter int         REG_ADDR_WIDTH = 4,
  parameter int         FILTER_DEPTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe_o,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [7:0]                rd_data_o,
  output logic                      wr_strobe_o,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]                wr_data_o,
  output logic                      busy_o
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [1:0] scl_s, sda_s;
  logic       scl_f, sda_f;
  logic       scl_d, sda_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_DEPTH + 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  // a level is accepted after FILTER_DEPTH samples differing from it
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_DEPTH - 1)) begin
        scl_f   <= scl_s[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_DEPTH - 1)) begin
        sda_f   <= sda_s[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_f = scl_s[1];
  assign sda_f = sda_s[1];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  logic [7:0]                regs [DEPTH];
  state_t                    state;
  logic [2:0]                bitcnt;
  logic [7:0]                shreg;
  logic [REG_ADDR_WIDTH-1:0] ptr;
  logic                      rw, got, mack;
  logic [7:0]                rx;
  logic                      last;

  assign rx        = {shreg[6:0], sda_f};
  assign last      = (bitcnt == 3'd7);
  assign rd_data_o = regs[rd_addr_i];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      got         <= 1'b0;
      mack        <= 1'b1;
      sda_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe_o <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bitcnt   <= '0;
        sda_oe_o <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg  <= rx;
            bitcnt <= bitcnt + 3'd1;
            if (last) begin
              if (rx[7:1] == DEVICE_ADDR) begin
                state  <= ADDR_ACK;
                rw     <= rx[0];
                busy_o <= 1'b1;
              end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end
          end
          PTR: if (scl_rise) begin
            shreg  <= rx;
            bitcnt <= bitcnt + 3'd1;
            if (last) begin
              ptr   <= rx[REG_ADDR_WIDTH-1:0];
              state <= PTR_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            shreg  <= rx;
            bitcnt <= bitcnt + 3'd1;
            if (last) begin
              regs[ptr]   <= rx;
              wr_strobe_o <= 1'b1;
              wr_addr_o   <= ptr;
              wr_data_o   <= rx;
              ptr         <= ptr + 1'b1;
              state       <= WDATA_ACK;
            end
          end
          // sda_oe_o doubles as the "ACK already driven" marker
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else begin
              bitcnt <= '0;
              if (state == ADDR_ACK && rw) begin
                shreg    <= regs[ptr];
                sda_oe_o <= ~regs[ptr][7];
                state    <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 3'd1;
              if (last) begin
                state <= RDATA_ACK;
                got   <= 1'b0;
                ptr   <= ptr + 1'b1;
              end
            end else if (scl_fall) begin
              shreg    <= {shreg[6:0], 1'b0};
              sda_oe_o <= ~shreg[6];
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              got  <= 1'b1;
              mack <= sda_f;
            end else if (scl_fall) begin
              if (!got) begin
                sda_oe_o <= 1'b0;
              end else if (!mack) begin
                shreg    <= regs[ptr];
                sda_oe_o <= ~regs[ptr][7];
                bitcnt   <= '0;
                state    <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bus-level master tasks, transaction model, per-cycle compare.
// Filter scenario runs only when I2C_TARGET_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regfile dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .scl_i       (scl),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mregs [16];
  logic [3:0] mptr = 4'd0;
  int         expq [$];
  int         wlog [$];
  bit         chk_en = 1'b0;
  bit         oe_ok = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // per-cycle compare, sampled 3 ns after the active edge
  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      if (wr_strobe) begin
        if (expq.size() == 0) begin
          chk("unexpected strobe", 32'(wr_addr), 32'hffff);
        end else begin
          int e;
          e = expq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e / 256));
          chk("wr_data", 32'(wr_data), 32'(e % 256));
          mregs[e / 256] = 8'(e % 256);
          wlog.push_back(e);
        end
      end
      chk("rd_data", 32'(rd_data), 32'(mregs[rd_addr]));
      if (!oe_ok) chk("sda_oe quiet", 32'(sda_oe), 32'd0);
    end
  end

  task automatic wq(input int n = Q);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1; wq();
    sda_m = 1'b1; wq(2 * Q);
  endtask

  task automatic wbit(input logic b, input bit glitch = 1'b0);
    sda_m = b; wq();
    scl = 1'b1;
    if (glitch) begin
      wq(8);
      scl = 1'b0; wq(2);
      scl = 1'b1; wq(10);
    end else begin
      wq(2 * Q);
    end
    scl = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    b = sda_line; wq();
    scl = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack,
                       input int gbit = -1);
    for (int i = 7; i >= 0; i--) wbit(v[i], i == gbit);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] v, input logic nack);
    for (int i = 7; i >= 0; i--) rbit(v[i]);
    wbit(nack);
  endtask

  task automatic write_txn(input logic [3:0] p, input int n,
                           input logic [7:0] d0, input logic [7:0] d1);
    logic ack;
    logic [7:0] d;
    i2c_start();
    wbyte(8'hA0, ack); chk("ack addr", 32'(ack), 0);
    wbyte(8'(p), ack); chk("ack ptr", 32'(ack), 0);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      expq.push_back(int'(4'(p + 4'(i))) * 256 + int'(d));
      wbyte(d, ack); chk("ack data", 32'(ack), 0);
    end
    chk("busy before P", 32'(busy), 1);
    i2c_stop();
    chk("busy after P", 32'(busy), 0);
    mptr = 4'(p + 4'(n));
  endtask

  initial begin
    logic ack;
    logic [7:0] v;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    wq(5);
    chk("reset sda_oe", 32'(sda_oe), 0);
    chk("reset wr_strobe", 32'(wr_strobe), 0);
    chk("reset wr_addr", 32'(wr_addr), 0);
    chk("reset wr_data", 32'(wr_data), 0);
    chk("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    wq(5);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); wq(1);
      chk("reset reg", 32'(rd_data), 0);
    end
    chk_en = 1'b1;

    // write 0x11, 0x22 starting at register 3
    write_txn(4'd3, 2, 8'h11, 8'h22);
    rd_addr = 4'd4; wq(2);
    chk("reg4 literal", 32'(rd_data), 32'h22);
    chk("strobe count", 32'(wlog.size()), 2);
    chk("strobe1 literal", 32'(wlog[0]), 32'h311);
    chk("strobe2 literal", 32'(wlog[1]), 32'h422);

    // random read through repeated START
    i2c_start();
    wbyte(8'hA0, ack); chk("rr ack addr", 32'(ack), 0);
    wbyte(8'h03, ack); chk("rr ack ptr", 32'(ack), 0);
    mptr = 4'd3;
    i2c_start();
    wbyte(8'hA1, ack); chk("rr ack raddr", 32'(ack), 0);
    chk("rr busy", 32'(busy), 1);
    rbyte(v, 1'b0);
    chk("rr byte0 model", 32'(v), 32'(mregs[mptr])); mptr++;
    chk("rr byte0 literal", 32'(v), 32'h11);
    rbyte(v, 1'b1);
    chk("rr byte1 model", 32'(v), 32'(mregs[mptr])); mptr++;
    chk("rr byte1 literal", 32'(v), 32'h22);
    wq(2);
    chk("rr released after nack", 32'(sda_oe), 0);
    chk("rr busy before P", 32'(busy), 1);
    i2c_stop();
    chk("rr busy after P", 32'(busy), 0);

    // address mismatch: no ACK, no write, never busy
    oe_ok = 1'b0;
    i2c_start();
    wbyte(8'hA2, ack); chk("mm ack addr", 32'(ack), 1);
    wbyte(8'h55, ack); chk("mm ack data", 32'(ack), 1);
    chk("mm busy", 32'(busy), 0);
    i2c_stop();
    oe_ok = 1'b1;
    chk("mm no strobe", 32'(wlog.size()), 2);

    // pointer wrap from 15 to 0
    write_txn(4'd15, 2, 8'hAA, 8'hBB);
    chk("wrap addr0", 32'(wlog[2] / 256), 15);
    chk("wrap addr1", 32'(wlog[3] / 256), 0);

    // reset while the target drives a 0 bit
    write_txn(4'd3, 0, 8'h00, 8'h00);
    i2c_start();
    wbyte(8'hA1, ack); chk("rst ack", 32'(ack), 0);
    chk("rst driving bit7", 32'(sda_oe), 1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst releases sda", 32'(sda_oe), 0);
    wq(3);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'd0;
    expq.delete();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); wq(1);
      chk("rst reg cleared", 32'(rd_data), 0);
    end
    chk_en = 1'b1;
    i2c_stop();
    write_txn(4'd5, 1, 8'h5A, 8'h00);
    i2c_start();
    wbyte(8'hA0, ack); chk("post ack addr", 32'(ack), 0);
    wbyte(8'h05, ack); chk("post ack ptr", 32'(ack), 0);
    i2c_start();
    wbyte(8'hA1, ack); chk("post ack raddr", 32'(ack), 0);
    rbyte(v, 1'b1);
    chk("post read literal", 32'(v), 32'h5A);
    i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // 2-cycle SCL glitch inside bit 3 must be swallowed
    i2c_start();
    wbyte(8'hA0, ack); chk("flt ack addr", 32'(ack), 0);
    wbyte(8'h07, ack); chk("flt ack ptr", 32'(ack), 0);
    expq.push_back(7 * 256 + 8'h5C);
    wbyte(8'h5C, ack, 3); chk("flt ack data", 32'(ack), 0);
    i2c_stop();
    rd_addr = 4'd7; wq(2);
    chk("flt reg7 literal", 32'(rd_data), 32'h5C);
`endif

    wq(5);
    chk("queue drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
